// File: rtl/note_pkg.sv
// note_pkg: shared types and constants for the note sequencer.
//   state_t   - sequencer FSM states (IDLE, PLAY, PAUSE, DONE)
//   note_t    - 4-bit note index (0..11 = C..B, 12..15 = rest)
//   FREQ_TBL  - note frequencies in Hz, indexed by note_t
//   hp_table  - elaboration-time half-period table for a given clock
//   MELODY    - melody ROM (note + 2-bit duration code), up to 64 steps
package note_pkg;

  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, DONE} state_t;

  typedef logic [3:0] note_t;

  localparam note_t REST = 4'd15;

  typedef struct packed {
    note_t       note;
    logic [1:0]  dur;   // step length is dur+1 beats
  } rom_entry_t;

  localparam int unsigned ROM_DEPTH = 64;

  // Element [0] is C (261 Hz), element [11] is B (494 Hz).
  localparam logic [11:0][11:0] FREQ_TBL = {
    12'd494, 12'd466, 12'd440, 12'd415, 12'd392, 12'd370,
    12'd349, 12'd330, 12'd311, 12'd293, 12'd277, 12'd261
  };

  typedef logic [11:0][21:0] hp_tbl_t;

  // Half-period in clocks, round(clk_hz / (2*f)), clamped to 22 bits.
  function automatic hp_tbl_t hp_table(input longint unsigned clk_hz);
    hp_tbl_t          tbl;
    longint unsigned  f;
    longint unsigned  h;
    tbl = '0;
    for (int unsigned i = 0; i < 12; i++) begin
      f = 64'(FREQ_TBL[i]);
      h = (clk_hz + f) / (64'd2 * f);
      tbl[i] = (h > 64'h3F_FFFF) ? '1 : h[21:0];
    end
    return tbl;
  endfunction

  function automatic logic [11:0] note_freq(input note_t n);
    return (n < 4'd12) ? FREQ_TBL[n] : 12'd0;
  endfunction

  localparam rom_entry_t MELODY [ROM_DEPTH] = '{
    0:  '{note: 4'd0,  dur: 2'd0},
    1:  '{note: 4'd4,  dur: 2'd1},
    2:  '{note: REST,  dur: 2'd0},
    3:  '{note: 4'd9,  dur: 2'd0},
    4:  '{note: 4'd7,  dur: 2'd1},
    5:  '{note: 4'd5,  dur: 2'd0},
    6:  '{note: 4'd4,  dur: 2'd0},
    7:  '{note: 4'd2,  dur: 2'd0},
    8:  '{note: 4'd0,  dur: 2'd1},
    9:  '{note: REST,  dur: 2'd0},
    10: '{note: 4'd7,  dur: 2'd0},
    11: '{note: 4'd9,  dur: 2'd0},
    12: '{note: 4'd11, dur: 2'd0},
    13: '{note: 4'd0,  dur: 2'd0},
    14: '{note: 4'd2,  dur: 2'd1},
    15: '{note: 4'd0,  dur: 2'd3},
    default: '{note: REST, dur: 2'd0}
  };

endpackage

// File: rtl/tone_gen.sv
// tone_gen: square-wave speaker driver.
//   clk, rst_n  - clock, async active-low reset
//   freq        - current note frequency (0 = silence)
//   half_period - clocks between spk toggles for the current note
//   spk         - square-wave output, 0 whenever silent
module tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] freq,
  input  logic [21:0] half_period,
  output logic        spk
);

  logic [11:0] last_freq;
  logic [21:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_freq <= '0;
      cnt       <= '0;
      spk       <= 1'b0;
    end else begin
      last_freq <= freq;
      // Silence or a fresh note restarts the waveform from spk=0.
      if (freq == '0 || freq != last_freq) begin
        cnt <= '0;
        spk <= 1'b0;
      end else if (cnt == half_period - 22'd1) begin
        cnt <= '0;
        spk <= ~spk;
      end else if (cnt != '1) begin
        cnt <= cnt + 22'd1;
      end
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays a melody ROM as timed note frequencies.
//   Build option: define NOTE_SEQ_LOOP_EN to wrap the melody forever
//   instead of stopping in DONE.
//   clk, rst_n        - clock, async active-low reset
//   play, pause, stop - single-cycle control pulses (stop > pause > play)
//   freq              - registered note frequency in Hz, 0 when silent
//   step              - registered current melody step
//   busy              - registered, high in PLAY or PAUSE
//   spk               - square-wave speaker drive
module note_sequencer
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned BEAT_CYCLES = 25_000_000,
  parameter int unsigned SEQ_LEN     = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        play,
  input  logic        pause,
  input  logic        stop,
  output logic [11:0] freq,
  output logic [5:0]  step,
  output logic        busy,
  output logic        spk
);

  localparam hp_tbl_t     HP_TBL    = hp_table(64'(CLK_HZ));
  localparam logic [5:0]  LAST_STEP = 6'(SEQ_LEN - 1);
  localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);

  function automatic logic [21:0] note_hp(input note_t n);
    return (n < 4'd12) ? HP_TBL[n] : 22'd0;
  endfunction

  state_t      state, state_n;
  logic [5:0]  step_n, nxt_step;
  logic [11:0] freq_n;
  logic        busy_n;
  logic [31:0] beat_cnt, beat_cnt_n;
  logic [1:0]  beat_num, beat_num_n;
  logic [21:0] half_period, half_period_n;
  rom_entry_t  cur, nxt, first;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      step        <= '0;
      freq        <= '0;
      busy        <= 1'b0;
      beat_cnt    <= '0;
      beat_num    <= '0;
      half_period <= '0;
    end else begin
      state       <= state_n;
      step        <= step_n;
      freq        <= freq_n;
      busy        <= busy_n;
      beat_cnt    <= beat_cnt_n;
      beat_num    <= beat_num_n;
      half_period <= half_period_n;
    end
  end

  always_comb begin
    state_n       = state;
    step_n        = step;
    freq_n        = freq;
    beat_cnt_n    = beat_cnt;
    beat_num_n    = beat_num;
    half_period_n = half_period;
    cur           = MELODY[step];
    first         = MELODY[0];
    nxt_step      = (step == LAST_STEP) ? '0 : step + 6'd1;
    nxt           = MELODY[nxt_step];

    if (stop) begin
      state_n       = IDLE;
      step_n        = '0;
      freq_n        = '0;
      beat_cnt_n    = '0;
      beat_num_n    = '0;
      half_period_n = '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (!pause && play) begin
            state_n       = PLAY;
            step_n        = '0;
            beat_cnt_n    = '0;
            beat_num_n    = '0;
            freq_n        = note_freq(first.note);
            half_period_n = note_hp(first.note);
          end
        end
        PLAY: begin
          // Pause freezes the beat counters on the cycle it is taken.
          if (pause) begin
            state_n       = PAUSE;
            freq_n        = '0;
            half_period_n = '0;
          end else if (beat_cnt != BEAT_LAST) begin
            beat_cnt_n = beat_cnt + 32'd1;
          end else begin
            beat_cnt_n = '0;
            if (beat_num != cur.dur) begin
              beat_num_n = beat_num + 2'd1;
            end else begin
              beat_num_n = '0;
              if (step != LAST_STEP) begin
                step_n        = nxt_step;
                freq_n        = note_freq(nxt.note);
                half_period_n = note_hp(nxt.note);
              end else begin
`ifdef NOTE_SEQ_LOOP_EN
                step_n        = '0;
                freq_n        = note_freq(first.note);
                half_period_n = note_hp(first.note);
`else
                state_n       = DONE;
                freq_n        = '0;
                half_period_n = '0;
`endif
              end
            end
          end
        end
        PAUSE: begin
          if (!pause && play) begin
            state_n       = PLAY;
            freq_n        = note_freq(cur.note);
            half_period_n = note_hp(cur.note);
          end
        end
        default: state_n = IDLE;
      endcase
    end

    busy_n = (state_n == PLAY) || (state_n == PAUSE);
  end

  tone_gen u_tone (
    .clk         (clk),
    .rst_n       (rst_n),
    .freq        (freq),
    .half_period (half_period),
    .spk         (spk)
  );

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed bench for note_sequencer.
// Melody head: C/d0, E/d1, rest/d0, A/d0 with SEQ_LEN=4.
// A second instance with longer beats is used for tone-period checks.
module tb_note_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        play = 1'b0, pause = 1'b0, stop = 1'b0;
  logic        play_s = 1'b0;
  logic [11:0] freq, freq_s;
  logic [5:0]  step, step_s;
  logic        busy, busy_s, spk, spk_s;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int iv;

  always #5 clk = ~clk;

  note_sequencer #(.CLK_HZ(10_000), .BEAT_CYCLES(10), .SEQ_LEN(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .play  (play),
    .pause (pause),
    .stop  (stop),
    .freq  (freq),
    .step  (step),
    .busy  (busy),
    .spk   (spk)
  );

  note_sequencer #(.CLK_HZ(10_000), .BEAT_CYCLES(40), .SEQ_LEN(4)) dut_slow (
    .clk   (clk),
    .rst_n (rst_n),
    .play  (play_s),
    .pause (1'b0),
    .stop  (1'b0),
    .freq  (freq_s),
    .step  (step_s),
    .busy  (busy_s),
    .spk   (spk_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Cycles between two consecutive spk edges on the slow instance; -1 on timeout.
  task automatic spk_interval(output int ival);
    logic last;
    int   n;
    ival = -1;
    last = spk_s;
    n = 0;
    while (spk_s === last && n < 60) begin tick(); n++; end
    if (spk_s === last) return;
    last = spk_s;
    n = 0;
    while (spk_s === last && n < 60) begin tick(); n++; end
    if (spk_s !== last) ival = n;
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    check("rst_freq", freq, 0);
    check("rst_step", step, 0);
    check("rst_busy", busy, 0);
    check("rst_spk",  spk,  0);
    #9 rst_n = 1'b1;

    // Basic playback timing
    goto(5); play = 1'b1; tick(); play = 1'b0;
    check("c_freq", freq, 261);
    check("c_busy", busy, 1);
    check("c_step", step, 0);
    goto(15); check("c_last", freq, 261);
    goto(16); check("e_freq", freq, 330); check("e_step", step, 1);
    goto(35); check("e_last", freq, 330);
    goto(36); check("rest_freq", freq, 0); check("rest_step", step, 2);
    check("rest_busy", busy, 1);
    goto(40); check("rest_spk", spk, 0);
    goto(46); check("a_freq", freq, 440); check("a_step", step, 3);
    goto(55); check("a_last", freq, 440);
    goto(56);
`ifdef NOTE_SEQ_LOOP_EN
    check("wrap_step", step, 0); check("wrap_freq", freq, 261); check("wrap_busy", busy, 1);
`else
    check("done_step", step, 3); check("done_freq", freq, 0); check("done_busy", busy, 0);
`endif

    // Stop returns to IDLE
    goto(60); stop = 1'b1; tick(); stop = 1'b0;
    check("stop_busy", busy, 0); check("stop_step", step, 0); check("stop_freq", freq, 0);

    // Pause three cycles into E, resume twenty cycles later
    goto(65); play = 1'b1; tick(); play = 1'b0;
    goto(76); check("e2_freq", freq, 330);
    goto(79); pause = 1'b1; tick(); pause = 1'b0;
    check("pause_freq", freq, 0); check("pause_busy", busy, 1); check("pause_step", step, 1);
    goto(90); check("pause_hold", freq, 0);
    goto(99); play = 1'b1; tick(); play = 1'b0;
    check("resume_freq", freq, 330);
    goto(116); check("resume_last", freq, 330);
    goto(117); check("resume_end", freq, 0); check("resume_step", step, 2);

    // All three pulses together: stop wins
    goto(120); play = 1'b1; pause = 1'b1; stop = 1'b1; tick();
    play = 1'b0; pause = 1'b0; stop = 1'b0;
    check("prio_busy", busy, 0); check("prio_step", step, 0); check("prio_freq", freq, 0);

    // Asynchronous reset in the middle of E
    goto(125); play = 1'b1; tick(); play = 1'b0;
    goto(140); check("pre_rst_step", step, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_freq", freq, 0); check("arst_step", step, 0);
    check("arst_busy", busy, 0); check("arst_spk", spk, 0);
    #2 rst_n = 1'b1;
    goto(150);
    check("idle_freq", freq, 0); check("idle_busy", busy, 0); check("idle_step", step, 0);
    play = 1'b1; tick(); play = 1'b0;
    check("replay_freq", freq, 261); check("replay_busy", busy, 1);

    // Tone periods on the slow instance (play at 160)
    goto(160); play_s = 1'b1; tick(); play_s = 1'b0;
    check("slow_c_freq", freq_s, 261);
    spk_interval(iv); check("tone_c", iv, 19);
    goto(205); spk_interval(iv); check("tone_e", iv, 15);
    goto(290); check("slow_rest_freq", freq_s, 0); check("slow_rest_spk", spk_s, 0);
    goto(310); spk_interval(iv); check("tone_a", iv, 11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
